data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 35 +++
 rtl/data_memory_responder.sv | 140 ++++++++++++++
 tb/tb_data_memory_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data memory responder and its storage.
//   state_t           : responder FSM state encoding (IDLE=0, WAIT=1, DONE=2)
//   DMEM_BASE_DEFAULT : default byte address of word 0
//   dmem_aw()         : word-index width for a given depth (at least 1 bit)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

    function automatic int unsigned dmem_aw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage with synchronous write and
// asynchronous read. Contents are never reset.
//   clk     : write clock
//   i_we    : write strobe
//   i_idx   : word index (read and write)
//   i_be    : byte-lane mask for writes, bit i covers bits 8i+7..8i
//   i_wdata : write data
//   o_rdata : word currently addressed by i_idx
module dmem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency data memory slave for a multicycle
// datapath. A request accepted in IDLE completes LATENCY cycles later with a
// one-cycle ready pulse; misaligned or out-of-range addresses complete one
// cycle after acceptance with err set and no side effects.
// Optional feature macro: DMEM_BYTE_EN (adds byteen lane mask for writes).
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   req    : access request (sampled only in IDLE)
//   we     : 1 = write, 0 = read
//   addr   : byte address
//   wdata  : store data
//   byteen : byte-lane enables (DMEM_BYTE_EN only)
//   rdata  : load data, held until the next completed legal read
//   ready  : one-cycle completion pulse
//   err    : error flag, valid with ready
//   busy   : high whenever not IDLE
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] BASE    = DMEM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  byteen,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW = dmem_aw(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic          r_err;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_be;

    logic [31:0]   w_word;
    logic          w_bad;
    logic          w_accept;
    logic          w_complete;
    logic          w_mem_we;
    logic [3:0]    w_be;
    logic [31:0]   w_mem_rdata;

    // Unsigned wrap makes addresses below BASE land far out of range.
    assign w_word     = (addr - BASE) >> 2;
    assign w_bad      = (addr[1:0] != 2'b00) || (w_word >= 32'(DEPTH));
    assign w_accept   = (r_state == IDLE) && req;
    assign w_complete = (r_state == WAIT) && (r_cnt == 4'd1);
    // Reset on the completion edge must still suppress the write.
    assign w_mem_we   = w_complete && r_we && !reset;

`ifdef DMEM_BYTE_EN
    assign w_be = byteen;
`else
    assign w_be = '1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (req) w_next = w_bad ? DONE : WAIT;
            WAIT: if (r_cnt == 4'd1) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ready = (r_state == DONE);
        err   = (r_state == DONE) && r_err;
        busy  = (r_state != IDLE);
        rdata = r_rdata;
    end

    // Request capture, latency counter and load data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_idx   <= '0;
            r_be    <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= w_bad ? 4'd0 : 4'(LATENCY);
                r_we    <= we;
                r_err   <= w_bad;
                r_wdata <= wdata;
                r_idx   <= w_word[AW-1:0];
                r_be    <= w_be;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_complete && !r_we) begin
                r_rdata <= w_mem_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_idx   (r_idx),
        .i_be    (r_be),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed self-checking bench for
// data_memory_responder (DEPTH=1024, LATENCY=2, default BASE).
// Define DMEM_BYTE_EN to also exercise byte-lane writes.
module tb_data_memory_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DMEM_BYTE_EN
    logic [3:0]  byteen;
`endif
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    data_memory_responder #(
        .DEPTH   (1024),
        .LATENCY (2),
        .BASE    (32'h1001_0000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
`ifdef DMEM_BYTE_EN
        .byteen (byteen),
`endif
        .rdata  (rdata),
        .ready  (ready),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access from an IDLE cycle (#1 after an edge), then check
    // completion latency, err and rdata in the ready cycle, and return to IDLE.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rdata);
        int k;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        k = 1;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, ".lat"},   32'(k),     32'(exp_lat));
        check({tag, ".err"},   32'(err),   32'(exp_err));
        check({tag, ".rdata"}, rdata,      exp_rdata);
        @(posedge clk); #1;
        check({tag, ".idle"},  32'({ready, busy}), 32'd0);
    endtask

    initial begin
        logic [9:0] bv;
        logic [9:0] rv;
        int n;

        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
`ifdef DMEM_BYTE_EN
        byteen = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst.rdata", rdata, 32'd0);
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.err",   32'(err),   32'd0);
        check("rst.busy",  32'(busy),  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic write/read with LATENCY=2: ready in the 3rd cycle after E0
        access("wr04",   1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0000);
        access("rd04",   1'b0, 32'h1001_0004, 32'h0,         3, 1'b0, 32'hDEAD_BEEF);
        access("wr00",   1'b1, 32'h1001_0000, 32'h0102_0304, 3, 1'b0, 32'hDEAD_BEEF);

        // Error completions: misaligned, below BASE, just past the end
        access("rdmis",  1'b0, 32'h1001_0002, 32'h0,         1, 1'b1, 32'hDEAD_BEEF);
        access("rdlow",  1'b0, 32'h1000_FFFC, 32'h0,         1, 1'b1, 32'hDEAD_BEEF);
        access("wrhigh", 1'b1, 32'h1001_1000, 32'h5555_5555, 1, 1'b1, 32'hDEAD_BEEF);

        // Last legal word
        access("wrlast", 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 3, 1'b0, 32'hDEAD_BEEF);
        access("rdlast", 1'b0, 32'h1001_0FFC, 32'h0,         3, 1'b0, 32'hCAFE_F00D);
        access("rd00",   1'b0, 32'h1001_0000, 32'h0,         3, 1'b0, 32'h0102_0304);

        // Reset on the completion edge of a pending write discards it
        access("wr08",   1'b1, 32'h1001_0008, 32'hA5A5_A5A5, 3, 1'b0, 32'h0102_0304);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h1001_0008;
        wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req = 1'b0;
        check("rstw.busy0", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("rstw.busy1", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstw.state", 32'({ready, err, busy}), 32'd0);
        check("rstw.rdata", rdata, 32'd0);
        access("rd08",   1'b0, 32'h1001_0008, 32'h0,         3, 1'b0, 32'hA5A5_A5A5);

        // req held high for 10 edges: expect re-acceptance right after DONE
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h1001_0004;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bv[i] = busy;
            rv[i] = ready;
        end
        req = 1'b0;
        check("hold.busy",   32'(bv), 32'(10'b11_0111_0111));
        check("hold.ready",  32'(rv), 32'(10'b00_0100_0100));
        check("hold.consec", 32'(rv & (rv >> 1)), 32'd0);
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold.drain", 32'(busy), 32'd0);
        check("hold.rdata", rdata, 32'hDEAD_BEEF);

`ifdef DMEM_BYTE_EN
        access("bewr1",  1'b1, 32'h1001_000C, 32'h1111_1111, 3, 1'b0, 32'hDEAD_BEEF);
        byteen = 4'b0101;
        access("bewr2",  1'b1, 32'h1001_000C, 32'hAABB_CCDD, 3, 1'b0, 32'hDEAD_BEEF);
        byteen = 4'b0000;
        access("bewr0",  1'b1, 32'h1001_000C, 32'hFFFF_FFFF, 3, 1'b0, 32'hDEAD_BEEF);
        byteen = 4'hF;
        access("berd",   1'b0, 32'h1001_000C, 32'h0,         3, 1'b0, 32'h11BB_11DD);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
